// File: rtl/adc_ad7175_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_ad7175_ctrl
// Description : Transaction sequencer for an AD7175-class sigma-delta ADC.
//               Accepts single register reads and writes, or continuous
//               conversion reads, from a host. Frames each transfer with chip
//               select setup, hold and idle timing, and hands the byte-level
//               work to an external serial comm engine.
// Ports       : xclk/reset            - clock, async active-low reset
//               host_*                - request strobe/op/fields, results,
//                                       busy and done
//               sample_*              - continuous conversion results
//               adc_err               - sticky conversion error flag
//               adc_cs_n              - ADC chip select
//               comm_*                - serial comm engine handshake and data
// Revision    : 1.0 - initial release
// ============================================================================
module adc_ad7175_ctrl #(
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        host_go,
  input  logic [1:0]  host_op,
  input  logic [5:0]  host_addr,
  input  logic [1:0]  host_len,
  input  logic [23:0] host_wdata,
  output logic [23:0] host_rdata,
  output logic        host_busy,
  output logic        host_done,
  output logic [23:0] sample_data,
  output logic [1:0]  sample_ch,
  output logic        sample_valid,
  output logic [15:0] sample_count,
  output logic        adc_err,
  output logic        adc_cs_n,
  output logic        comm_start,
  input  logic        comm_busy,
  output logic        comm_wait_for_ready,
  output logic [7:0]  comm_cmd,
  output logic [1:0]  comm_len,
  output logic [23:0] comm_wdata,
  input  logic [31:0] comm_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ISSUE   = 3'd2,
    S_ACK     = 3'd3,
    S_DONE    = 3'd4,
    S_HOLD    = 3'd5,
    S_RECOVER = 3'd6
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CONT  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;
  localparam int         CNT_W    = 16;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               go_prev_q;
  logic [1:0]         op_q, op_d;
  logic [5:0]         addr_q, addr_d;
  logic [1:0]         len_q, len_d;
  logic [23:0]        wdata_q, wdata_d;
  logic               stop_q, stop_d;
  logic               cs_n_q, cs_n_d;
  logic [23:0]        rdata_q, rdata_d;
  logic [23:0]        sdata_q, sdata_d;
  logic [1:0]         sch_q, sch_d;
  logic               svalid_q, svalid_d;
  logic [15:0]        scount_q, scount_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic go_edge;
  logic go_stop;
  logic go_txn;
  logic cont_mode;

  assign go_edge   = host_go & ~go_prev_q;
  assign go_stop   = go_edge & (host_op == OP_STOP);
  assign go_txn    = go_edge & (host_op != OP_STOP);
  assign cont_mode = (op_q == OP_CONT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    stop_d   = stop_q;
    cs_n_d   = cs_n_q;
    rdata_d  = rdata_q;
    sdata_d  = sdata_q;
    sch_d    = sch_q;
    svalid_d = 1'b0;
    scount_d = scount_q;
    err_d    = err_q;
    done_d   = 1'b0;

    // A stop is only remembered here; it is acted on at the end of RECOVER
    // so the transfer in flight always completes.
    if (go_stop && (state_q != S_IDLE)) begin
      stop_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (go_txn) begin
          op_d    = host_op;
          addr_d  = host_addr;
          len_d   = host_len;
          wdata_d = host_wdata;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SETUP;
          if (host_op == OP_CONT) begin
            scount_d = '0;
            err_d    = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (comm_busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!comm_busy) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          if (cont_mode) begin
            sdata_d  = comm_rdata[31:8];
            sch_d    = comm_rdata[1:0];
            svalid_d = 1'b1;
            scount_d = scount_q + 16'd1;
            if (comm_rdata[6]) begin
              err_d = 1'b1;
            end
          end else if (op_q == OP_READ) begin
            rdata_d = comm_rdata[23:0];
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cs_n_d  = 1'b1;
          cnt_d   = '0;
          done_d  = ~cont_mode;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          // A stop edge arriving on this very cycle counts as pending.
          if (cont_mode && !stop_q && !go_stop) begin
            cs_n_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_SETUP;
          end else begin
            stop_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      go_prev_q <= 1'b0;
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      stop_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rdata_q   <= '0;
      sdata_q   <= '0;
      sch_q     <= '0;
      svalid_q  <= 1'b0;
      scount_q  <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      go_prev_q <= host_go;
      op_q      <= op_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      stop_q    <= stop_d;
      cs_n_q    <= cs_n_d;
      rdata_q   <= rdata_d;
      sdata_q   <= sdata_d;
      sch_q     <= sch_d;
      svalid_q  <= svalid_d;
      scount_q  <= scount_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Command fields come straight from the latched request, which only changes
  // in IDLE, so they are stable for the whole engine handshake.
  always_comb begin
    comm_cmd            = {2'b00, addr_q};
    comm_len            = len_q;
    comm_wdata          = wdata_q;
    comm_wait_for_ready = 1'b0;
    case (op_q)
      OP_READ: begin
        comm_cmd   = {2'b01, addr_q};
        comm_wdata = '0;
      end
      OP_CONT: begin
        comm_cmd            = 8'h44;
        comm_len            = 2'b11;
        comm_wdata          = '0;
        comm_wait_for_ready = 1'b1;
      end
      default: begin
        comm_cmd = {2'b00, addr_q};
      end
    endcase
  end

  assign comm_start   = (state_q == S_ISSUE) || (state_q == S_ACK);
  assign host_busy    = (state_q != S_IDLE);
  assign host_done    = done_q;
  assign host_rdata   = rdata_q;
  assign sample_data  = sdata_q;
  assign sample_ch    = sch_q;
  assign sample_valid = svalid_q;
  assign sample_count = scount_q;
  assign adc_err      = err_q;
  assign adc_cs_n     = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_ad7175_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_ad7175_ctrl
// Description : Directed self-checking bench for adc_ad7175_ctrl with a
//               behavioural serial comm engine answering from a table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_ad7175_ctrl;

  logic        xclk = 1'b0;
  logic        reset = 1'b0;
  logic        host_go = 1'b0;
  logic [1:0]  host_op = '0;
  logic [5:0]  host_addr = '0;
  logic [1:0]  host_len = '0;
  logic [23:0] host_wdata = '0;
  logic [23:0] host_rdata;
  logic        host_busy;
  logic        host_done;
  logic [23:0] sample_data;
  logic [1:0]  sample_ch;
  logic        sample_valid;
  logic [15:0] sample_count;
  logic        adc_err;
  logic        adc_cs_n;
  logic        comm_start;
  logic        comm_busy;
  logic        comm_wait_for_ready;
  logic [7:0]  comm_cmd;
  logic [1:0]  comm_len;
  logic [23:0] comm_wdata;
  logic [31:0] comm_rdata;

  adc_ad7175_ctrl #(.CS_SETUP(4), .CS_HOLD(4), .CS_IDLE(8)) dut (
    .xclk(xclk), .reset(reset),
    .host_go(host_go), .host_op(host_op), .host_addr(host_addr),
    .host_len(host_len), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_busy(host_busy), .host_done(host_done),
    .sample_data(sample_data), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .sample_count(sample_count),
    .adc_err(adc_err), .adc_cs_n(adc_cs_n), .comm_start(comm_start),
    .comm_busy(comm_busy), .comm_wait_for_ready(comm_wait_for_ready),
    .comm_cmd(comm_cmd), .comm_len(comm_len), .comm_wdata(comm_wdata),
    .comm_rdata(comm_rdata)
  );

  always #5 xclk = ~xclk;

  // Behavioural comm engine: answers each start with the next table entry.
  logic [31:0] eng_tbl [0:15];
  int          eng_rd = 0;
  int          eng_cnt = 0;
  logic        eng_hang = 1'b0;

  always @(posedge xclk or negedge reset) begin
    if (!reset) begin
      comm_busy <= 1'b0;
      eng_cnt   <= 0;
    end else if (!comm_busy) begin
      if (comm_start && !eng_hang) begin
        comm_busy  <= 1'b1;
        eng_cnt    <= 5;
        comm_rdata <= eng_tbl[eng_rd[3:0]];
        eng_rd     <= eng_rd + 1;
      end
    end else if (eng_cnt == 0) begin
      comm_busy <= 1'b0;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  // Event monitor, sampled on the falling edge.
  int          cyc = 0;
  int          cs_fall_cyc = 0;
  int          start_cyc = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          valid_cnt = 0;
  logic        prev_cs_n = 1'b1;
  logic        prev_start = 1'b0;
  logic [7:0]  cmd_at_start = '0;
  logic [1:0]  len_at_start = '0;
  logic [23:0] wdata_at_start = '0;
  logic        wfr_at_start = 1'b0;
  logic [23:0] sd_cap [0:7];
  logic [1:0]  sch_cap [0:7];
  logic        err_cap [0:7];

  always @(negedge xclk) begin
    cyc        <= cyc + 1;
    prev_cs_n  <= adc_cs_n;
    prev_start <= comm_start;
    if (prev_cs_n && !adc_cs_n) cs_fall_cyc <= cyc;
    if (!prev_start && comm_start) begin
      start_cnt      <= start_cnt + 1;
      start_cyc      <= cyc;
      cmd_at_start   <= comm_cmd;
      len_at_start   <= comm_len;
      wdata_at_start <= comm_wdata;
      wfr_at_start   <= comm_wait_for_ready;
    end
    if (host_done) done_cnt <= done_cnt + 1;
    if (sample_valid) begin
      sd_cap[valid_cnt[2:0]]  <= sample_data;
      sch_cap[valid_cnt[2:0]] <= sample_ch;
      err_cap[valid_cnt[2:0]] <= adc_err;
      valid_cnt               <= valid_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] a,
                      input logic [1:0] l, input logic [23:0] w);
    host_op    = op;
    host_addr  = a;
    host_len   = l;
    host_wdata = w;
    host_go    = 1'b1;
    @(negedge xclk);
    host_go    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge xclk);
    while (host_busy !== 1'b0 && n < 1000) begin
      @(negedge xclk);
      n++;
    end
    check_eq(tag, {31'd0, host_busy}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge xclk);
  endtask

  int s0, d0, v0, n;

  initial begin
    eng_tbl[0] = 32'h0000_0000;
    eng_tbl[1] = 32'h0000_00CD;
    eng_tbl[2] = 32'hABCD_EF01;
    eng_tbl[3] = 32'h1122_3342;
    eng_tbl[4] = 32'h0000_0003;
    eng_tbl[5] = 32'h5566_7741;
    eng_tbl[6] = 32'h0000_0077;
    eng_tbl[7] = 32'h9912_3456;
    for (int i = 8; i < 16; i++) eng_tbl[i] = 32'hDEAD_BEEF;

    // Reset state
    idle_cycles(3);
    check_eq("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check_eq("rst_start", {31'd0, comm_start}, 32'd0);
    check_eq("rst_busy", {31'd0, host_busy}, 32'd0);
    check_eq("rst_cmd", {24'd0, comm_cmd}, 32'd0);
    check_eq("rst_wfr", {31'd0, comm_wait_for_ready}, 32'd0);
    check_eq("rst_count", {16'd0, sample_count}, 32'd0);
    reset = 1'b1;
    idle_cycles(2);

    // Register write
    s0 = start_cnt; d0 = done_cnt;
    send(2'b00, 6'h01, 2'b01, 24'h123400);
    wait_idle("wr_idle");
    check_eq("wr_cmd", {24'd0, cmd_at_start}, 32'h01);
    check_eq("wr_len", {30'd0, len_at_start}, 32'h1);
    check_eq("wr_wdata", {8'd0, wdata_at_start}, 32'h123400);
    check_eq("wr_wfr", {31'd0, wfr_at_start}, 32'd0);
    check_eq("wr_setup_cycles", start_cyc - cs_fall_cyc, 32'd4);
    check_eq("wr_done_pulses", done_cnt - d0, 32'd1);
    check_eq("wr_starts", start_cnt - s0, 32'd1);
    check_eq("wr_cs_n", {31'd0, adc_cs_n}, 32'd1);

    // Register read
    d0 = done_cnt;
    send(2'b01, 6'h07, 2'b01, 24'hFFFFFF);
    wait_idle("rd_idle");
    check_eq("rd_cmd", {24'd0, cmd_at_start}, 32'h47);
    check_eq("rd_wdata", {8'd0, wdata_at_start}, 32'h0);
    check_eq("rd_rdata", {8'd0, host_rdata}, 32'h0000CD);
    check_eq("rd_done_pulses", done_cnt - d0, 32'd1);

    // Continuous mode, three samples then stop
    s0 = start_cnt; d0 = done_cnt; v0 = valid_cnt;
    send(2'b10, 6'h00, 2'b00, 24'h0);
    n = 0;
    while (valid_cnt < v0 + 3 && n < 2000) begin @(negedge xclk); n++; end
    send(2'b11, 6'h00, 2'b00, 24'h0);
    wait_idle("cont_idle");
    check_eq("cont_cmd", {24'd0, cmd_at_start}, 32'h44);
    check_eq("cont_len", {30'd0, len_at_start}, 32'h3);
    check_eq("cont_wfr", {31'd0, wfr_at_start}, 32'd1);
    check_eq("cont_valids", valid_cnt - v0, 32'd3);
    check_eq("cont_sd0", {8'd0, sd_cap[0]}, 32'hABCDEF);
    check_eq("cont_sd1", {8'd0, sd_cap[1]}, 32'h112233);
    check_eq("cont_sd2", {8'd0, sd_cap[2]}, 32'h000000);
    check_eq("cont_ch0", {30'd0, sch_cap[0]}, 32'd1);
    check_eq("cont_ch1", {30'd0, sch_cap[1]}, 32'd2);
    check_eq("cont_ch2", {30'd0, sch_cap[2]}, 32'd3);
    check_eq("cont_err0", {31'd0, err_cap[0]}, 32'd0);
    check_eq("cont_err1", {31'd0, err_cap[1]}, 32'd1);
    check_eq("cont_err2", {31'd0, err_cap[2]}, 32'd1);
    check_eq("cont_count", {16'd0, sample_count}, 32'd3);
    check_eq("cont_starts", start_cnt - s0, 32'd3);
    check_eq("cont_no_done", done_cnt - d0, 32'd0);

    // Stop during DONE of the first sample of a new continuous run
    s0 = start_cnt; v0 = valid_cnt;
    send(2'b10, 6'h00, 2'b00, 24'h0);
    @(negedge xclk);
    check_eq("stop_err_cleared", {31'd0, adc_err}, 32'd0);
    check_eq("stop_count_cleared", {16'd0, sample_count}, 32'd0);
    n = 0;
    while (!(comm_busy && !comm_start) && n < 200) begin @(negedge xclk); n++; end
    check_eq("stop_reached_done", {31'd0, comm_busy}, 32'd1);
    send(2'b11, 6'h00, 2'b00, 24'h0);
    wait_idle("stop_idle");
    idle_cycles(30);
    check_eq("stop_valids", valid_cnt - v0, 32'd1);
    check_eq("stop_sd", {8'd0, sd_cap[3]}, 32'h556677);
    check_eq("stop_count", {16'd0, sample_count}, 32'd1);
    check_eq("stop_err", {31'd0, adc_err}, 32'd1);
    check_eq("stop_starts", start_cnt - s0, 32'd1);
    check_eq("stop_cs_n", {31'd0, adc_cs_n}, 32'd1);

    // Request during SETUP is dropped
    s0 = start_cnt; d0 = done_cnt;
    send(2'b01, 6'h05, 2'b00, 24'h0);
    @(negedge xclk);
    send(2'b00, 6'h3F, 2'b10, 24'hFFFFFF);
    wait_idle("ign_idle");
    idle_cycles(30);
    check_eq("ign_cmd", {24'd0, cmd_at_start}, 32'h45);
    check_eq("ign_len", {30'd0, len_at_start}, 32'h0);
    check_eq("ign_wdata", {8'd0, wdata_at_start}, 32'h0);
    check_eq("ign_rdata", {8'd0, host_rdata}, 32'h000077);
    check_eq("ign_starts", start_cnt - s0, 32'd1);
    check_eq("ign_done_pulses", done_cnt - d0, 32'd1);

    // Reset while waiting in ACK
    eng_hang = 1'b1;
    send(2'b01, 6'h02, 2'b10, 24'h0);
    n = 0;
    while (comm_start !== 1'b1 && n < 100) begin @(negedge xclk); n++; end
    idle_cycles(3);
    check_eq("ack_start_held", {31'd0, comm_start}, 32'd1);
    check_eq("ack_cs_n_low", {31'd0, adc_cs_n}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check_eq("arst_start", {31'd0, comm_start}, 32'd0);
    check_eq("arst_busy", {31'd0, host_busy}, 32'd0);
    check_eq("arst_cmd", {24'd0, comm_cmd}, 32'd0);
    check_eq("arst_rdata", {8'd0, host_rdata}, 32'd0);
    check_eq("arst_sdata", {8'd0, sample_data}, 32'd0);
    check_eq("arst_count", {16'd0, sample_count}, 32'd0);
    check_eq("arst_err", {31'd0, adc_err}, 32'd0);
    @(negedge xclk);
    reset = 1'b1;
    eng_hang = 1'b0;
    idle_cycles(2);
    d0 = done_cnt;
    send(2'b01, 6'h02, 2'b10, 24'h0);
    wait_idle("post_idle");
    check_eq("post_cmd", {24'd0, cmd_at_start}, 32'h42);
    check_eq("post_len", {30'd0, len_at_start}, 32'h2);
    check_eq("post_rdata", {8'd0, host_rdata}, 32'h123456);
    check_eq("post_done_pulses", done_cnt - d0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
